sram_port_master: RTL and testbench

SRAM_PORT_MASTER -- requirements
Module: sram_port_master

---
 rtl/sram_port_master.sv | 200 ++++++++++++++++++++
 tb/tb_sram_port_master.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_master.sv
// rtl/sram_port_master.sv - byte/half/word load-store master for a byte-enabled single-port SRAM
//
// Ports:
//   clock, reset_n                 single clock, asynchronous active-low reset
//   req_valid/req_ready            request handshake; ready only while idle
//   req_write, req_addr, req_size  store/load, byte address, size (0=B 1=H 2=W 3=illegal)
//   req_unsigned, req_wdata        load zero-extend select, right-aligned store data
//   resp_valid/resp_ready          response handshake
//   resp_rdata, resp_err           extended load data (0 for stores/errors), failure flag
//   sram_en/we/addr/wdata/rdata    SRAM port, 1-cycle registered read, output held while en=0
//
// Build option: SRAM_PORT_MASTER_MISALIGNED_EN splits misaligned accesses across two
// words; without it misaligned requests return resp_err and never touch the SRAM.

module sram_port_master #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [31:0]           req_addr,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  sram_en,
  output logic [3:0]            sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [31:0]           sram_wdata,
  input  logic [31:0]           sram_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

  state_t state, state_nxt;

  logic                  q_write;
  logic                  q_uns;
  logic                  q_err;
  logic [1:0]            q_size;
  logic [ADDR_WIDTH+1:0] q_addr;
  logic [31:0]           q_wdata;

  // Address bits above the SRAM word range are deliberately ignored.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+2];

  // An access crosses a word boundary when offset + size bytes exceeds 4.
  function automatic logic misaligned(input logic [1:0] off, input logic [1:0] size);
    return ((size == 2'd1) && (off == 2'd3)) || ((size == 2'd2) && (off != 2'd0));
  endfunction

  logic req_bad;
`ifdef SRAM_PORT_MASTER_MISALIGNED_EN
  assign req_bad = (req_size == 2'd3);
`else
  assign req_bad = (req_size == 2'd3) || misaligned(req_addr[1:0], req_size);
`endif

  logic [1:0]            off;
  logic [4:0]            sh;
  logic [ADDR_WIDTH-1:0] word_w;
  logic [3:0]            size_mask;
  logic [3:0]            lo_mask;
  logic [31:0]           lo_data;

  assign off     = q_addr[1:0];
  assign sh      = {off, 3'b000};
  assign word_w  = q_addr[ADDR_WIDTH+1:2];
  assign lo_data = q_wdata << sh;

  always_comb begin
    case (q_size)
      2'd0:    size_mask = 4'b0001;
      2'd1:    size_mask = 4'b0011;
      default: size_mask = 4'b1111;
    endcase
  end

  assign lo_mask = size_mask << off;

`ifdef SRAM_PORT_MASTER_MISALIGNED_EN
  logic                  split;
  logic [31:0]           q_buf;
  logic [ADDR_WIDTH-1:0] word_w1;
  logic [3:0]            hi_mask;
  logic [31:0]           hi_data;
  logic [63:0]           ld_cat;

  assign split   = misaligned(off, q_size);
  assign word_w1 = word_w + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  // Bytes shifted out of the low word spill into the next word.
  assign hi_mask = 4'(({4'b0000, size_mask} << off) >> 4);
  assign hi_data = q_wdata >> (6'd32 - {1'b0, sh});
  // The first word was parked in q_buf during ACC1; sram_rdata now holds word W+1.
  assign ld_cat  = split ? {sram_rdata, q_buf} : {32'b0, sram_rdata};
`endif

  logic [31:0] ld_shift;
  logic [31:0] ld_ext;

`ifdef SRAM_PORT_MASTER_MISALIGNED_EN
  assign ld_shift = 32'(ld_cat >> sh);
`else
  assign ld_shift = sram_rdata >> sh;
`endif

  always_comb begin
    case (q_size)
      2'd0:    ld_ext = q_uns ? {24'b0, ld_shift[7:0]} : {{24{ld_shift[7]}}, ld_shift[7:0]};
      2'd1:    ld_ext = q_uns ? {16'b0, ld_shift[15:0]} : {{16{ld_shift[15]}}, ld_shift[15:0]};
      default: ld_ext = ld_shift;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      q_write <= 1'b0;
      q_uns   <= 1'b0;
      q_err   <= 1'b0;
      q_size  <= 2'd0;
      q_addr  <= '0;
      q_wdata <= 32'b0;
`ifdef SRAM_PORT_MASTER_MISALIGNED_EN
      q_buf   <= 32'b0;
`endif
    end else begin
      state <= state_nxt;
      if ((state == IDLE) && req_valid) begin
        q_write <= req_write;
        q_uns   <= req_unsigned;
        q_err   <= req_bad;
        q_size  <= req_size;
        q_addr  <= req_addr[ADDR_WIDTH+1:0];
        q_wdata <= req_wdata;
      end
`ifdef SRAM_PORT_MASTER_MISALIGNED_EN
      if (state == ACC1) begin
        q_buf <= sram_rdata;
      end
`endif
    end
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 32'b0;
    resp_err   = 1'b0;
    sram_en    = 1'b0;
    sram_we    = 4'b0000;
    sram_addr  = '0;
    sram_wdata = 32'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = req_bad ? RESP : ACC0;
        end
      end
      ACC0: begin
        sram_en    = 1'b1;
        sram_addr  = word_w;
        sram_we    = q_write ? lo_mask : 4'b0000;
        sram_wdata = lo_data;
`ifdef SRAM_PORT_MASTER_MISALIGNED_EN
        state_nxt  = split ? ACC1 : RESP;
`else
        state_nxt  = RESP;
`endif
      end
`ifdef SRAM_PORT_MASTER_MISALIGNED_EN
      ACC1: begin
        sram_en    = 1'b1;
        sram_addr  = word_w1;
        sram_we    = q_write ? hi_mask : 4'b0000;
        sram_wdata = hi_data;
        state_nxt  = RESP;
      end
`endif
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = q_err;
        resp_rdata = (q_err || q_write) ? 32'b0 : ld_ext;
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_port_master.sv
// tb/tb_sram_port_master.sv - directed self-checking bench for sram_port_master

module tb_sram_port_master;

  localparam int AW = 10;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [31:0]   req_addr;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic          sram_en;
  logic [3:0]    sram_we;
  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [31:0]   sram_rdata;

  always #5 clock = ~clock;

  sram_port_master #(.ADDR_WIDTH(AW)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  // Byte-enabled SRAM, registered read of the pre-write contents, output held while en=0.
  logic [31:0] mem [0:(1<<AW)-1];

  always @(posedge clock) begin
    if (sram_en) begin
      sram_rdata <= mem[sram_addr];
      for (int b = 0; b < 4; b++) begin
        if (sram_we[b]) mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end
    end
  end

  int          n_vec  = 0;
  int          n_miss = 0;
  int          lat;
  int          n_acc;
  logic [31:0] r_data;
  logic        r_err;
  logic [31:0] a_addr  [2];
  logic [31:0] a_we    [2];
  logic [31:0] a_wdata [2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic sample_acc();
    if (sram_en && n_acc < 2) begin
      a_addr[n_acc]  = 32'(sram_addr);
      a_we[n_acc]    = 32'(sram_we);
      a_wdata[n_acc] = sram_wdata;
      n_acc++;
    end
  endtask

  // Issue one request; returns latency in edges from acceptance to first resp_valid sample.
  task automatic do_req(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wd);
    @(negedge clock);
    check_eq("req_ready_idle", 32'(req_ready), 32'd1);
    req_write    = wr;
    req_addr     = addr;
    req_size     = size;
    req_unsigned = uns;
    req_wdata    = wd;
    req_valid    = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
    n_acc = 0;
    lat   = 1;
    @(negedge clock);
    sample_acc();
    while (!resp_valid && lat < 10) begin
      @(negedge clock);
      lat++;
      sample_acc();
    end
    r_data = resp_rdata;
    r_err  = resp_err;
  endtask

  task automatic end_resp();
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    @(negedge clock);
    check_eq("idle_after_hs", 32'(req_ready), 32'd1);
    check_eq("valid_after_hs", 32'(resp_valid), 32'd0);
  endtask

  task automatic chk_ok(input string tag, input logic [31:0] exp_data, input int exp_lat,
                        input int exp_nacc);
    check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_err"}, 32'(r_err), 32'd0);
    check_eq({tag, "_rdata"}, r_data, exp_data);
    check_eq({tag, "_nacc"}, 32'(n_acc), 32'(exp_nacc));
  endtask

  task automatic chk_err(input string tag);
    check_eq({tag, "_lat"}, 32'(lat), 32'd1);
    check_eq({tag, "_err"}, 32'(r_err), 32'd1);
    check_eq({tag, "_rdata"}, r_data, 32'd0);
    check_eq({tag, "_nacc"}, 32'(n_acc), 32'd0);
  endtask

  task automatic chk_acc(input string tag, input int idx, input logic [31:0] exp_addr,
                         input logic [31:0] exp_we, input logic [31:0] exp_wd, input bit chk_wd);
    check_eq({tag, "_addr"}, a_addr[idx], exp_addr);
    check_eq({tag, "_we"}, a_we[idx], exp_we);
    if (chk_wd) check_eq({tag, "_wdata"}, a_wdata[idx], exp_wd);
  endtask

  task automatic chk_reset_outputs(input string tag);
    check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    check_eq({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check_eq({tag, "_resp_err"}, 32'(resp_err), 32'd0);
    check_eq({tag, "_sram_en"}, 32'(sram_en), 32'd0);
    check_eq({tag, "_sram_we"}, 32'(sram_we), 32'd0);
    check_eq({tag, "_sram_addr"}, 32'(sram_addr), 32'd0);
    check_eq({tag, "_sram_wdata"}, sram_wdata, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
    sram_rdata   = 32'd0;
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_write    = 1'b0;
    req_addr     = 32'd0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'd0;
    resp_ready   = 1'b0;
    repeat (2) @(negedge clock);
    chk_reset_outputs("rst");
    reset_n = 1'b1;

    // Aligned word store, then sub-word loads out of the same word.
    do_req(1'b1, 32'h40, 2'd2, 1'b0, 32'hDEADBEEF);
    chk_ok("st_w", 32'd0, 2, 1);
    chk_acc("st_w", 0, 32'h10, 32'hF, 32'hDEADBEEF, 1'b1);
    end_resp();

    do_req(1'b0, 32'h43, 2'd0, 1'b0, 32'd0);
    chk_ok("ld_sb43", 32'hFFFFFFDE, 2, 1);
    chk_acc("ld_sb43", 0, 32'h10, 32'h0, 32'd0, 1'b0);
    end_resp();

    do_req(1'b0, 32'h41, 2'd0, 1'b1, 32'd0);
    chk_ok("ld_ub41", 32'h000000BE, 2, 1);
    end_resp();

    do_req(1'b0, 32'h42, 2'd1, 1'b0, 32'd0);
    chk_ok("ld_sh42", 32'hFFFFDEAD, 2, 1);
    end_resp();

    do_req(1'b0, 32'h40, 2'd1, 1'b1, 32'd0);
    chk_ok("ld_uh40", 32'h0000BEEF, 2, 1);
    end_resp();

    // Byte store into lane 1, aligned half store into the upper half.
    do_req(1'b1, 32'h45, 2'd0, 1'b0, 32'h0000005A);
    chk_ok("st_b45", 32'd0, 2, 1);
    chk_acc("st_b45", 0, 32'h11, 32'h2, 32'h00005A00, 1'b1);
    end_resp();

    do_req(1'b0, 32'h44, 2'd2, 1'b0, 32'd0);
    chk_ok("ld_w44", 32'h00005A00, 2, 1);
    end_resp();

    do_req(1'b1, 32'h06, 2'd1, 1'b0, 32'h00001234);
    chk_ok("st_h06", 32'd0, 2, 1);
    chk_acc("st_h06", 0, 32'h1, 32'hC, 32'h12340000, 1'b1);
    end_resp();

    do_req(1'b0, 32'h06, 2'd1, 1'b0, 32'd0);
    chk_ok("ld_sh06", 32'h00001234, 2, 1);
    end_resp();

    // Upper address bits are ignored.
    do_req(1'b0, 32'h1040, 2'd2, 1'b0, 32'd0);
    chk_ok("ld_hi", 32'hDEADBEEF, 2, 1);
    chk_acc("ld_hi", 0, 32'h10, 32'h0, 32'd0, 1'b0);
    end_resp();

    // Illegal size.
    do_req(1'b1, 32'h40, 2'd3, 1'b0, 32'h12345678);
    chk_err("size3");
    end_resp();

`ifdef SRAM_PORT_MASTER_MISALIGNED_EN
    do_req(1'b1, 32'h07, 2'd1, 1'b0, 32'h0000A55A);
    chk_ok("st_h07", 32'd0, 3, 2);
    chk_acc("st_h07_a0", 0, 32'h1, 32'h8, 32'h5A000000, 1'b1);
    chk_acc("st_h07_a1", 1, 32'h2, 32'h1, 32'h000000A5, 1'b1);
    end_resp();

    do_req(1'b0, 32'h07, 2'd1, 1'b1, 32'd0);
    chk_ok("ld_uh07", 32'h0000A55A, 3, 2);
    end_resp();

    do_req(1'b0, 32'h07, 2'd1, 1'b0, 32'd0);
    chk_ok("ld_sh07", 32'hFFFFA55A, 3, 2);
    end_resp();

    do_req(1'b1, 32'hFFC, 2'd2, 1'b0, 32'h11223344);
    chk_ok("st_w3ff", 32'd0, 2, 1);
    chk_acc("st_w3ff", 0, 32'h3FF, 32'hF, 32'h11223344, 1'b1);
    end_resp();

    do_req(1'b1, 32'h000, 2'd2, 1'b0, 32'h55667788);
    chk_ok("st_w000", 32'd0, 2, 1);
    end_resp();

    do_req(1'b0, 32'hFFD, 2'd2, 1'b0, 32'd0);
    chk_ok("ld_wrap", 32'h88112233, 3, 2);
    chk_acc("ld_wrap_a0", 0, 32'h3FF, 32'h0, 32'd0, 1'b0);
    chk_acc("ld_wrap_a1", 1, 32'h000, 32'h0, 32'd0, 1'b0);
    end_resp();
`else
    do_req(1'b1, 32'h07, 2'd1, 1'b0, 32'h0000A55A);
    chk_err("mis_h07");
    end_resp();

    do_req(1'b0, 32'hFFD, 2'd2, 1'b0, 32'd0);
    chk_err("mis_wffd");
    end_resp();

    // The rejected store must not have reached word 1 or 2.
    do_req(1'b0, 32'h04, 2'd2, 1'b0, 32'd0);
    chk_ok("ld_w04", 32'h12340000, 2, 1);
    end_resp();
`endif

    // Back-pressure: response held stable while resp_ready is low.
    do_req(1'b0, 32'h40, 2'd2, 1'b1, 32'd0);
    chk_ok("stall", 32'hDEADBEEF, 2, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      check_eq("stall_valid", 32'(resp_valid), 32'd1);
      check_eq("stall_rdata", resp_rdata, 32'hDEADBEEF);
      check_eq("stall_req_ready", 32'(req_ready), 32'd0);
    end
    end_resp();

    // Reset in the middle of an access.
    @(negedge clock);
    req_write    = 1'b0;
    req_size     = 2'd2;
    req_unsigned = 1'b0;
`ifdef SRAM_PORT_MASTER_MISALIGNED_EN
    req_addr     = 32'h41;
`else
    req_addr     = 32'h40;
`endif
    req_valid    = 1'b1;
    @(posedge clock);
    #1 req_valid = 1'b0;
`ifdef SRAM_PORT_MASTER_MISALIGNED_EN
    @(posedge clock);
`endif
    #2;
    check_eq("pre_rst_en", 32'(sram_en), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_outputs("mid_rst");
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check_eq("post_rst_valid", 32'(resp_valid), 32'd0);
    end

    do_req(1'b0, 32'h40, 2'd2, 1'b0, 32'd0);
    chk_ok("after_rst", 32'hDEADBEEF, 2, 1);
    end_resp();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
